serial_rx_word_bank: RTL and testbench

Downstream consumer of the serial receive controller. Captures each received 16-bit word into a shadow bank indexed by the word selector, then commits the whole bank atomically to the output registers only when the frame's CRC has been validated and every word was received. Provides a frame-commit pulse, a frame counter and a link watchdog, so control logic always sees a coherent, CRC-checked parameter set and learns when the link goes silent.

---
 rtl/serial_rx_word_bank_pkg.sv | 24 ++
 rtl/serial_rx_word_bank_rise_det.sv | 23 ++
 rtl/serial_rx_word_bank.sv | 178 +++++++++++++++++
 tb/tb_serial_rx_word_bank.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_word_bank_pkg.sv
// Shared constants and types for the serial receive word bank.
// Holds the word/selector widths, the frame size limit and the link state encoding.
package serial_rx_word_bank_pkg;

    localparam int WORD_W     = 16;
    localparam int SEL_W      = 8;
    localparam int MAX_N_WORD = 16;
    localparam int CNT_W      = 16;

    typedef enum logic {
        LINK_DOWN = 1'b0,
        LINK_UP   = 1'b1
    } link_state_e;

    // Index width for a bank of n words; a single-word bank still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_rx_word_bank_rise_det.sv
// One-bit registered rising-edge detector with synchronous active-high reset.
// The event is high in the first cycle the input is seen high after being low.
module rise_det (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d;

    // Delayed copy of the input level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/serial_rx_word_bank.sv
// Shadow bank for received words, committed atomically on a CRC-valid complete frame.
// Also provides a commit counter and a link watchdog.
module serial_rx_word_bank
    import serial_rx_word_bank_pkg::*;
#(
    parameter int N_WORD        = 1,
    parameter int TIMEOUT_CLKS  = 100000,
    parameter int CLEAR_ON_LOSS = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORD_W-1:0]          i_data_in,
    input  logic [SEL_W-1:0]           i_selector,
    input  logic                       i_data_strb,
    input  logic                       i_validate,
    output logic [WORD_W*N_WORD-1:0]   o_words_out,
    output logic                       o_frame_valid,
    output logic [CNT_W-1:0]           o_frame_cnt,
    output logic                       o_link_ok,
    output logic                       o_link_lost,
    output logic                       o_sel_err
);

    localparam int IDX_W = idx_width(N_WORD);
    localparam int WD_W  = $clog2(TIMEOUT_CLKS + 1);

    logic                      w_wr_ev;
    logic                      w_cm_ev;
    logic                      w_sel_ok;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_commit;
    logic                      w_expire;
    logic [N_WORD-1:0]         w_mask_next;
    logic [WD_W-1:0]           w_wd_next;
    logic [WORD_W*N_WORD-1:0]  w_shadow_flat;
    link_state_e               w_state_next;

    logic [WORD_W-1:0]         r_shadow [N_WORD];
    logic [N_WORD-1:0]         r_mask;
    logic [WD_W-1:0]           r_wd;
    link_state_e               r_state;
    logic [WORD_W*N_WORD-1:0]  r_words_out;
    logic                      r_frame_valid;
    logic [CNT_W-1:0]          r_frame_cnt;
    logic                      r_link_lost;
    logic                      r_sel_err;

    rise_det u_strb_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (i_data_strb),
        .o_rise (w_wr_ev)
    );

    rise_det u_val_det (
        .clk    (clk),
        .reset  (reset),
        .i_sig  (i_validate),
        .o_rise (w_cm_ev)
    );

    assign w_sel_ok = (i_selector < SEL_W'(N_WORD));
    assign w_idx    = i_selector[IDX_W-1:0];
    assign w_commit = w_cm_ev & (&r_mask);
    // A commit in the expiry cycle keeps the link up.
    assign w_expire = (r_state == LINK_UP) && (r_wd == WD_W'(TIMEOUT_CLKS - 1)) && !w_commit;

    // Flatten the shadow bank into the output word layout
    always_comb begin
        w_shadow_flat = '0;
        for (int k = 0; k < N_WORD; k++) begin
            w_shadow_flat[WORD_W*k +: WORD_W] = r_shadow[k];
        end
    end

    // Next mask: commit clears first, then a same-cycle write applies on top
    always_comb begin
        w_mask_next = r_mask;
        if (w_commit) begin
            w_mask_next = '0;
        end else begin
            w_mask_next = r_mask;
        end
        if (w_wr_ev && w_sel_ok) begin
            if (i_selector == SEL_W'(0)) begin
                w_mask_next = N_WORD'(1);
            end else begin
                w_mask_next[w_idx] = 1'b1;
            end
        end else begin
            w_mask_next = w_mask_next;
        end
    end

    // Watchdog next value, saturating at the timeout
    always_comb begin
        w_wd_next = r_wd;
        if (w_commit) begin
            w_wd_next = '0;
        end else if (r_wd < WD_W'(TIMEOUT_CLKS)) begin
            w_wd_next = r_wd + WD_W'(1);
        end else begin
            w_wd_next = r_wd;
        end
    end

    // Link state next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LINK_DOWN: begin
                if (w_commit) begin
                    w_state_next = LINK_UP;
                end else begin
                    w_state_next = LINK_DOWN;
                end
            end
            LINK_UP: begin
                if (w_expire) begin
                    w_state_next = LINK_DOWN;
                end else begin
                    w_state_next = LINK_UP;
                end
            end
            default: w_state_next = LINK_DOWN;
        endcase
    end

    // Link state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LINK_DOWN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shadow bank, mask, watchdog and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_WORD; k++) begin
                r_shadow[k] <= '0;
            end
            r_mask        <= '0;
            r_wd          <= '0;
            r_words_out   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= '0;
            r_link_lost   <= 1'b0;
            r_sel_err     <= 1'b0;
        end else begin
            if (w_wr_ev && w_sel_ok) begin
                r_shadow[w_idx] <= i_data_in;
            end
            r_mask        <= w_mask_next;
            r_wd          <= w_wd_next;
            r_frame_valid <= w_commit;
            r_link_lost   <= w_expire;
            r_sel_err     <= r_sel_err | (w_wr_ev & ~w_sel_ok);
            if (w_commit) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_words_out <= w_shadow_flat;
            end else if (w_expire && (CLEAR_ON_LOSS != 0)) begin
                r_words_out <= '0;
            end
        end
    end

    assign o_words_out   = r_words_out;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_cnt   = r_frame_cnt;
    assign o_link_ok     = (r_state == LINK_UP);
    assign o_link_lost   = r_link_lost;
    assign o_sel_err     = r_sel_err;

endmodule

// File: tb/tb_serial_rx_word_bank.sv
// Scoreboard bench for serial_rx_word_bank with three 3-word instances:
// long timeout, short timeout clearing on loss, short timeout holding on loss.
module tb_serial_rx_word_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = 16'h0000;
    logic [7:0]  selector = 8'h00;
    logic        data_strb = 1'b0;
    logic        validate = 1'b0;

    logic [47:0] m_words, a_words, b_words;
    logic        m_fv, a_fv, b_fv;
    logic [15:0] m_cnt_o, a_cnt_o, b_cnt_o;
    logic        m_ok, a_ok, b_ok;
    logic        m_lost, a_lost, b_lost;
    logic        m_serr, a_serr, b_serr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [47:0] words;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    logic [15:0] s_shadow [3];
    logic [2:0]  s_mask;
    logic [15:0] s_cnt;
    logic [47:0] s_last;

    always #5 clk = ~clk;

    serial_rx_word_bank #(.N_WORD(3), .TIMEOUT_CLKS(1000), .CLEAR_ON_LOSS(1)) dut_m (
        .clk(clk), .reset(reset), .i_data_in(data_in), .i_selector(selector),
        .i_data_strb(data_strb), .i_validate(validate), .o_words_out(m_words),
        .o_frame_valid(m_fv), .o_frame_cnt(m_cnt_o), .o_link_ok(m_ok),
        .o_link_lost(m_lost), .o_sel_err(m_serr));

    serial_rx_word_bank #(.N_WORD(3), .TIMEOUT_CLKS(20), .CLEAR_ON_LOSS(1)) dut_a (
        .clk(clk), .reset(reset), .i_data_in(data_in), .i_selector(selector),
        .i_data_strb(data_strb), .i_validate(validate), .o_words_out(a_words),
        .o_frame_valid(a_fv), .o_frame_cnt(a_cnt_o), .o_link_ok(a_ok),
        .o_link_lost(a_lost), .o_sel_err(a_serr));

    serial_rx_word_bank #(.N_WORD(3), .TIMEOUT_CLKS(20), .CLEAR_ON_LOSS(0)) dut_b (
        .clk(clk), .reset(reset), .i_data_in(data_in), .i_selector(selector),
        .i_data_strb(data_strb), .i_validate(validate), .o_words_out(b_words),
        .o_frame_valid(b_fv), .o_frame_cnt(b_cnt_o), .o_link_ok(b_ok),
        .o_link_lost(b_lost), .o_sel_err(b_serr));

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) s_shadow[k] = 16'h0000;
        s_mask = 3'b000;
        s_cnt  = 16'h0000;
    endfunction

    function automatic void model_write(input logic [7:0] sel, input logic [15:0] d);
        if (sel < 8'd3) begin
            s_shadow[sel[1:0]] = d;
            if (sel == 8'd0) s_mask = 3'b001;
            else s_mask[sel[1:0]] = 1'b1;
        end
    endfunction

    function automatic void model_commit();
        exp_t e;
        if (s_mask == 3'b111) begin
            s_cnt   = s_cnt + 16'd1;
            e.words = {s_shadow[2], s_shadow[1], s_shadow[0]};
            e.cnt   = s_cnt;
            s_last  = e.words;
            exp_q.push_back(e);
            s_mask  = 3'b000;
        end
    endfunction

    // Output monitor: every commit pulse must match the oldest expected frame
    always @(negedge clk) begin
        if (!reset && (m_fv || a_fv || b_fv)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: frame_valid m/a/b=%b%b%b, required no pulse", m_fv, a_fv, b_fv);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({m_fv, a_fv, b_fv} !== 3'b111) begin
                    errors++;
                    $display("FAIL commit_pulse: m/a/b=%b%b%b, required 111", m_fv, a_fv, b_fv);
                end
                checks++;
                if (m_words !== e.words || a_words !== e.words || b_words !== e.words) begin
                    errors++;
                    $display("FAIL commit_words: m=%h a=%h b=%h, required %h", m_words, a_words, b_words, e.words);
                end
                checks++;
                if (m_cnt_o !== e.cnt || a_cnt_o !== e.cnt || b_cnt_o !== e.cnt) begin
                    errors++;
                    $display("FAIL commit_cnt: m=%h a=%h b=%h, required %h", m_cnt_o, a_cnt_o, b_cnt_o, e.cnt);
                end
            end
        end
    end

    task automatic drive_word(input logic [7:0] sel, input logic [15:0] d, input int hold);
        @(negedge clk);
        selector  = sel;
        data_in   = d;
        data_strb = 1'b1;
        model_write(sel, d);
        repeat (hold) @(negedge clk);
        data_strb = 1'b0;
    endtask

    task automatic pulse_validate();
        @(negedge clk);
        validate = 1'b1;
        model_commit();
        @(negedge clk);
        validate = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_commit: %0d frames outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic full_frame(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        drive_word(8'd0, w0, 1);
        drive_word(8'd1, w1, 1);
        drive_word(8'd2, w2, 1);
        pulse_validate();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_words, a_words, b_words} !== 144'h0 || {m_cnt_o, a_cnt_o, b_cnt_o} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: words/cnt nonzero m=%h/%h, required 0", m_words, m_cnt_o);
        end
        checks++;
        if ({m_fv, a_fv, b_fv, m_ok, a_ok, b_ok, m_lost, a_lost, b_lost, m_serr, a_serr, b_serr} !== 12'h000) begin
            errors++;
            $display("FAIL reset_flags: fv/ok/lost/serr m=%b%b%b%b, required 0000", m_fv, m_ok, m_lost, m_serr);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        full_frame(16'h1111, 16'h2222, 16'h3333);
        drain("full_frame");
        checks++;
        if (m_words !== 48'h3333_2222_1111 || m_cnt_o !== 16'd1 || m_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_frame_state: words=%h cnt=%0d ok=%b, required 333322221111 1 1", m_words, m_cnt_o, m_ok);
        end
    endtask

    task automatic test_missing_word();
        drive_word(8'd0, 16'h4444, 1);
        drive_word(8'd2, 16'h6666, 1);
        pulse_validate();
        drain("missing_word");
        checks++;
        if (m_words !== 48'h3333_2222_1111 || m_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL missing_word_hold: words=%h cnt=%0d, required 333322221111 1", m_words, m_cnt_o);
        end
        // The mask is still incomplete, so supplying word 1 now completes it.
        drive_word(8'd1, 16'h5555, 1);
        pulse_validate();
        drain("missing_word_fill");
    endtask

    task automatic test_held_strobe();
        drive_word(8'd1, 16'h0101, 1);
        drive_word(8'd2, 16'h0202, 1);
        drive_word(8'd0, 16'hAAAA, 10);
        drive_word(8'd0, 16'hBBBB, 1);
        pulse_validate();
        drain("held_strobe_incomplete");
        drive_word(8'd1, 16'hC1C1, 1);
        drive_word(8'd2, 16'hC2C2, 1);
        pulse_validate();
        drain("held_strobe");
        checks++;
        if (m_words[15:0] !== 16'hBBBB) begin
            errors++;
            $display("FAIL held_strobe_word0: %h, required BBBB", m_words[15:0]);
        end
    endtask

    task automatic test_sel_err();
        drive_word(8'd0, 16'hD000, 1);
        drive_word(8'd1, 16'hD001, 1);
        drive_word(8'd5, 16'hDEAD, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({m_serr, a_serr, b_serr} !== 3'b111) begin
            errors++;
            $display("FAIL sel_err_set: m/a/b=%b%b%b, required 111", m_serr, a_serr, b_serr);
        end
        drive_word(8'd2, 16'hD002, 1);
        pulse_validate();
        drain("sel_err_frame");
        checks++;
        if (m_serr !== 1'b1 || m_words !== 48'hD002_D001_D000) begin
            errors++;
            $display("FAIL sel_err_sticky: serr=%b words=%h, required 1 D002D001D000", m_serr, m_words);
        end
    endtask

    task automatic test_back_to_back();
        full_frame(16'hE000, 16'hE001, 16'hE002);
        drive_word(8'd0, 16'hF000, 1);
        drive_word(8'd1, 16'hF001, 1);
        drive_word(8'd2, 16'hF002, 1);
        // Commit and a selector-1 write in the same cycle.
        @(negedge clk);
        validate  = 1'b1;
        data_strb = 1'b1;
        selector  = 8'd1;
        data_in   = 16'h7777;
        model_commit();
        model_write(8'd1, 16'h7777);
        @(negedge clk);
        data_strb = 1'b0;
        drive_word(8'd2, 16'h7722, 1);
        drive_word(8'd0, 16'h7700, 1);
        drive_word(8'd1, 16'h7711, 1);
        drive_word(8'd2, 16'h7722, 1);
        // Validate is still high: a complete mask must not commit on the level.
        repeat (3) @(negedge clk);
        checks++;
        if (m_cnt_o !== s_cnt) begin
            errors++;
            $display("FAIL validate_level: cnt=%0d, required %0d", m_cnt_o, s_cnt);
        end
        validate = 1'b0;
        pulse_validate();
        drain("back_to_back");
    endtask

    task automatic test_link_loss();
        int n;
        bit seen;
        full_frame(16'h9000, 16'h9001, 16'h9002);
        n = 0;
        while (!a_fv && n < 5) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (a_lost) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 20) begin
            errors++;
            $display("FAIL link_lost_timing: seen=%b after %0d cycles, required 1 after 20", seen, n);
        end
        checks++;
        if (a_ok !== 1'b0 || b_ok !== 1'b0 || b_lost !== 1'b1 || m_ok !== 1'b1) begin
            errors++;
            $display("FAIL link_state: a_ok=%b b_ok=%b b_lost=%b m_ok=%b, required 0 0 1 1", a_ok, b_ok, b_lost, m_ok);
        end
        checks++;
        if (a_words !== 48'h0 || b_words !== s_last) begin
            errors++;
            $display("FAIL loss_words: a=%h b=%h, required 0 %h", a_words, b_words, s_last);
        end
        @(negedge clk);
        checks++;
        if (a_lost !== 1'b0 || a_ok !== 1'b0) begin
            errors++;
            $display("FAIL link_lost_pulse: lost=%b ok=%b, required 0 0", a_lost, a_ok);
        end
    endtask

    task automatic test_reset_midframe();
        drive_word(8'd0, 16'h1234, 1);
        drive_word(8'd1, 16'h5678, 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (m_words !== 48'h0 || m_cnt_o !== 16'h0 || m_ok !== 1'b0 || m_serr !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: words=%h cnt=%0d ok=%b serr=%b, required 0", m_words, m_cnt_o, m_ok, m_serr);
        end
        reset = 1'b0;
        drive_word(8'd2, 16'h9ABC, 1);
        pulse_validate();
        drain("discarded_frame");
        full_frame(16'hA0A0, 16'hA1A1, 16'hA2A2);
        drain("midframe_clean");
        checks++;
        if (m_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL midframe_cnt: %0d, required 1", m_cnt_o);
        end
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk);
        force dut_m.r_frame_cnt = 16'hFFFE;
        force dut_a.r_frame_cnt = 16'hFFFE;
        force dut_b.r_frame_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut_m.r_frame_cnt;
        release dut_a.r_frame_cnt;
        release dut_b.r_frame_cnt;
        s_cnt = 16'hFFFE;
        full_frame(16'h0F00, 16'h0F01, 16'h0F02);
        full_frame(16'h0E00, 16'h0E01, 16'h0E02);
        drain("cnt_wrap");
        checks++;
        if (m_cnt_o !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_wrap: %h, required 0000", m_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_missing_word();
        test_held_strobe();
        test_sel_err();
        test_back_to_back();
        test_link_loss();
        test_reset_midframe();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
